if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised instruction buffer between the fetch (IF) and decode (ID) stages. It replaces the single-entry IF/ID pipeline latch with a DEPTH-entry FIFO and valid/ready handshakes on both sides, so fetch can run ahead while decode stalls. Each entry carries pc, npc, instruction and branch prediction. A flush empties the whole queue in one cycle, and decode sees a NOP bubble whenever the queue is empty.

## Interface
- ADDR_W, 32, width of pc, npc and prediction fields
- INST_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥2
- NOP_INST, 32'h00000013, instruction presented to ID when empty (addi x0,x0,0)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict / exception redirect)
- if_valid  in  1  IF presents an entry
- if_ready  out  1  queue can accept an entry this cycle
- if_pc  in  ADDR_W  fetched pc
- if_npc  in  ADDR_W  sequential next pc
- if_inst  in  INST_W  fetched instruction
- if_pred  in  ADDR_W  predicted next pc
- id_valid  out  1  head entry valid
- id_ready  in  1  ID consumes head this cycle
- id_pc  out  ADDR_W  head pc
- id_npc  out  ADDR_W  head npc
- id_inst  out  INST_W  head instruction
- id_pred  out  ADDR_W  head prediction
- count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular array; wr_ptr, rd_ptr of log2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter cnt of CNT_W bits.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- if_ready = (cnt != DEPTH). It depends only on state, with no combinational path from id_ready.
- id_valid = (cnt != 0). It depends only on state.
- Head outputs when id_valid=1: the entry at rd_ptr.
- Head outputs when empty: id_pc=0, id_npc=0, id_pred=0, id_inst=NOP_INST.
- On push: write the entry at wr_ptr; wr_ptr += 1.
- On pop: rd_ptr += 1.
- cnt update: cnt += push − pop. Simultaneous push and pop leave cnt unchanged, and this is legal at any occupancy 1..DEPTH−1.
- Full with id_ready=1: the pop happens but no push, because if_ready=0. The push is accepted the following cycle.
- Empty: no pop, because id_valid=0. A push in the same cycle is not visible to ID until the next cycle; there is no bypass.
- Flush: on the next edge, rd_ptr=wr_ptr=0 and cnt=0. Any concurrent push and pop are discarded. Array contents are don't-care.
- rst: same effect as flush and has priority over everything. It applies mid-operation with immediate effect on the next edge.
- IF must hold if_* stable while if_valid=1 and if_ready=0. The queue does not check this.

## Timing
- Latency: an entry pushed at edge k appears on id_* with id_valid=1 from edge k+1 (1 cycle) when the queue was empty. Otherwise it appears after all older entries have popped.
- Throughput: 1 entry/cycle sustained when 0<cnt<DEPTH with both sides active.
- Reset values, valid from the first edge with rst=1 onward:
  - if_ready=1, id_valid=0, count=0
  - id_pc=0, id_npc=0, id_pred=0, id_inst=NOP_INST
- Flush asserted at edge k: from edge k+1, id_valid=0, if_ready=1, count=0. An IF entry presented during the flush cycle is lost, and IF must re-fetch from the redirect pc.
- No combinational paths: if_valid→if_ready, id_ready→id_valid, flush→any output.

## Test plan
- Reset/idle: assert rst for 2 cycles mid-traffic. Required after release: count=0, id_valid=0, if_ready=1, id_inst=0x00000013, id_pc=0.
- Fill/drain in order: DEPTH=4 with id_ready=0, push pcs 0x100, 0x104, 0x108, 0x10C. Required: count=4, if_ready=0, and a 5th push (0x110) is held off. Then id_ready=1: 0x100..0x10C pop in order, one per cycle, followed by 0x110.
- Streaming plus wrap: push/pop every cycle for 3·DEPTH entries with pc incrementing by 4. Required: count stays 1 after the first cycle, id_pc is always the oldest pc, and pointer wrap produces no gaps or duplicates.
- Full with simultaneous pop: at count=4, id_ready=1 and if_valid=1. Required: pop only, count=3, and the incoming entry is accepted the next cycle.
- Flush with concurrent push/pop: at count=3, flush=1 with if_valid=1 and id_ready=1. Required next cycle: count=0, id_valid=0, id_inst=NOP_INST, and neither the pushed nor the popped entry is later observed.
- Field integrity: push the entry pc=0x2000, npc=0x2004, inst=0xFE000EE3, pred=0x1FC0. Required: all four values are identical on id_* on the pop cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF/ID instruction FIFO with valid/ready handshakes, one-cycle flush and NOP bubble when empty
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [INST_W-1:0] NOP_INST = 'h13,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [ADDR_W-1:0] if_npc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] if_pred,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_npc,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pred,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] npc_q [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pred_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic push, pop;
  assign if_ready = cnt != CNT_W'(DEPTH);
  assign id_valid = cnt != '0;
  assign push = if_valid & if_ready & ~flush;
  assign pop = id_valid & id_ready & ~flush;
  assign count = cnt;
  always_comb begin
    id_pc = id_valid ? pc_q[rd_ptr] : '0;
    id_npc = id_valid ? npc_q[rd_ptr] : '0;
    id_inst = id_valid ? inst_q[rd_ptr] : NOP_INST;
    id_pred = id_valid ? pred_q[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= if_pc;
      npc_q[wr_ptr] <= if_npc;
      inst_q[wr_ptr] <= if_inst;
      pred_q[wr_ptr] <= if_pred;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: random and directed stimulus checked every cycle against a queue-based model
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic if_ready, id_valid;
  logic [31:0] if_pc = 0, if_npc = 0, if_inst = 0, if_pred = 0;
  logic [31:0] id_pc, id_npc, id_inst, id_pred;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] pc, npc, inst, pred; } ent_t;
  ent_t q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_npc(if_npc), .if_inst(if_inst), .if_pred(if_pred),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_npc(id_npc), .id_inst(id_inst), .id_pred(id_pred),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_step();
    bit pu, po;
    ent_t e;
    if (rst || flush) q.delete();
    else begin
      pu = if_valid && q.size() < DEPTH;
      po = id_ready && q.size() > 0;
      e = '{if_pc, if_npc, if_inst, if_pred};
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
    end
  endtask

  task automatic compare();
    bit emp = q.size() == 0;
    chk("count", 32'(count), 32'(q.size()));
    chk("id_valid", 32'(id_valid), 32'(!emp));
    chk("if_ready", 32'(if_ready), 32'(q.size() != DEPTH));
    chk("id_pc", id_pc, emp ? 32'h0 : q[0].pc);
    chk("id_npc", id_npc, emp ? 32'h0 : q[0].npc);
    chk("id_inst", id_inst, emp ? 32'h13 : q[0].inst);
    chk("id_pred", id_pred, emp ? 32'h0 : q[0].pred);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_if(input logic [31:0] pc);
    if_pc = pc;
    if_npc = pc + 4;
    if_inst = $urandom;
    if_pred = $urandom;
  endtask

  initial begin
    logic [31:0] exp_pc [5] = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h0};
    logic [31:0] exp_cnt [5] = '{3, 3, 2, 1, 0};
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_if_ready", 32'(if_ready), 1);
    chk("rst_id_inst", id_inst, 32'h13);
    rst = 0;
    if_valid = 1;
    for (int i = 0; i < 4; i++) begin
      set_if(32'h100 + 4 * i);
      tick();
    end
    chk("fill_count", 32'(count), 4);
    chk("fill_if_ready", 32'(if_ready), 0);
    set_if(32'h110);
    tick();
    chk("held_count", 32'(count), 4);
    chk("held_head", id_pc, 32'h100);
    id_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) if_valid = 0;
      tick();
      chk("drain_pc", id_pc, exp_pc[i]);
      chk("drain_count", 32'(count), exp_cnt[i]);
    end
    if_valid = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_if(32'h400 + 4 * i);
      tick();
      chk("stream_count", 32'(count), 1);
      chk("stream_pc", id_pc, 32'h400 + 4 * i);
    end
    if_valid = 0;
    tick();
    id_ready = 0;
    if_valid = 1;
    for (int i = 0; i < 3; i++) begin
      set_if(32'h800 + 4 * i);
      tick();
    end
    chk("pre_flush_count", 32'(count), 3);
    flush = 1;
    id_ready = 1;
    set_if(32'h900);
    tick();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(id_valid), 0);
    chk("flush_inst", id_inst, 32'h13);
    flush = 0;
    if_valid = 0;
    tick();
    chk("post_flush_valid", 32'(id_valid), 0);
    id_ready = 0;
    if_valid = 1;
    if_pc = 32'h2000;
    if_npc = 32'h2004;
    if_inst = 32'hFE000EE3;
    if_pred = 32'h1FC0;
    tick();
    if_valid = 0;
    id_ready = 1;
    chk("fld_pc", id_pc, 32'h2000);
    chk("fld_npc", id_npc, 32'h2004);
    chk("fld_inst", id_inst, 32'hFE000EE3);
    chk("fld_pred", id_pred, 32'h1FC0);
    tick();
    chk("fld_empty", 32'(id_valid), 0);
    for (int i = 0; i < 3000; i++) begin
      if_valid = $urandom_range(0, 3) != 0;
      id_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 127) == 0;
      if (!(if_valid && !if_ready)) set_if($urandom);
      tick();
    end
    flush = 0;
    rst = 0;
    if_valid = 1;
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_if(32'hA00 + 4 * i);
      tick();
    end
    rst = 1;
    id_ready = 1;
    tick();
    tick();
    rst = 0;
    if_valid = 0;
    tick();
    chk("rst2_count", 32'(count), 0);
    chk("rst2_valid", 32'(id_valid), 0);
    chk("rst2_if_ready", 32'(if_ready), 1);
    chk("rst2_inst", id_inst, 32'h13);
    chk("rst2_pc", id_pc, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
